// File: rtl/alu_mc_unit.sv
// Multicycle LEGv8 execute unit: ALU control decode plus an iterative ALU
// datapath. The request side accepts only in IDLE, and the result side holds
// its output until the consumer takes it. LSL/LSR move one bit per cycle and
// MUL is a DATA_W-step shift-add.
module alu_mc_unit #(
  parameter int DATA_W  = 64,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [10:0]        opcode,
  input  logic [1:0]         ALUOp,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic [3:0]         ALUCtl,
  output logic               err
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_ORR  = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_EOR  = 4'b0011;
  localparam logic [3:0] CTL_LSL  = 4'b0100;
  localparam logic [3:0] CTL_LSR  = 4'b0101;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_PASS = 4'b0111;
  localparam logic [3:0] CTL_MUL  = 4'b1000;
  localparam logic [3:0] CTL_ILL  = 4'b1111;

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SHIFT,
    S_MUL,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   opa_q, opa_d;     // operand A / shift value / multiplicand
  logic [DATA_W-1:0]   opb_q, opb_d;     // operand B / multiplier
  logic [DATA_W-1:0]   acc_q, acc_d;     // product accumulator
  logic [CNT_W-1:0]    cnt_q, cnt_d;     // remaining shift or multiply steps
  logic                nosh_q, nosh_d;   // shamt was zero: spend the step without shifting
  logic [3:0]          ctl_q, ctl_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;

  logic [3:0]          dec_ctl;
  logic                dec_err;
  logic [DATA_W-1:0]   exec_res;

  // Decode the incoming request; opcode is consulted only for ALUOp 10
  always_comb begin
    dec_ctl = CTL_ILL;
    dec_err = 1'b1;
    case (ALUOp)
      2'b00: begin
        dec_ctl = CTL_ADD;
        dec_err = 1'b0;
      end
      2'b01: begin
        dec_ctl = CTL_PASS;
        dec_err = 1'b0;
      end
      2'b10: begin
        dec_err = 1'b0;
        case (opcode)
          11'b10001011000: dec_ctl = CTL_ADD;
          11'b11001011000: dec_ctl = CTL_SUB;
          11'b10001010000: dec_ctl = CTL_AND;
          11'b10101010000: dec_ctl = CTL_ORR;
          11'b11001010000: dec_ctl = CTL_EOR;
          11'b11010011011: dec_ctl = CTL_LSL;
          11'b11010011010: dec_ctl = CTL_LSR;
          11'b10011011000: dec_ctl = CTL_MUL;
          default: begin
            dec_ctl = CTL_ILL;
            dec_err = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctl = CTL_ILL;
        dec_err = 1'b1;
      end
    endcase
  end

  // Single-cycle operations on the latched operands
  always_comb begin
    exec_res = '0;
    case (ctl_q)
      CTL_ADD:  exec_res = opa_q + opb_q;
      CTL_SUB:  exec_res = opa_q + ~opb_q + ONE;
      CTL_AND:  exec_res = opa_q & opb_q;
      CTL_ORR:  exec_res = opa_q | opb_q;
      CTL_EOR:  exec_res = opa_q ^ opb_q;
      CTL_PASS: exec_res = opb_q;
      default:  exec_res = '0;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    nosh_d   = nosh_q;
    ctl_d    = ctl_q;
    err_d    = err_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d  = a;
          opb_d  = b;
          acc_d  = '0;
          ctl_d  = dec_ctl;
          err_d  = dec_err;
          nosh_d = 1'b0;
          if (dec_ctl == CTL_LSL || dec_ctl == CTL_LSR) begin
            state_d = S_SHIFT;
            // shamt=0 still spends one step so its latency matches shamt=1
            if (shamt == '0) begin
              cnt_d  = CNT_W'(1);
              nosh_d = 1'b1;
            end else begin
              cnt_d  = {1'b0, shamt};
            end
          end else if (dec_ctl == CTL_MUL) begin
            state_d = S_MUL;
            cnt_d   = CNT_W'(DATA_W);
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        result_d = exec_res;
        zero_d   = (exec_res == '0);
        state_d  = S_DONE;
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          result_d = opa_q;
          zero_d   = (opa_q == '0);
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (!nosh_q) begin
            opa_d = (ctl_q == CTL_LSL) ? (opa_q << 1) : (opa_q >> 1);
          end
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          result_d = acc_q;
          zero_d   = (acc_q == '0);
          state_d  = S_DONE;
        end else begin
          if (opb_q[0]) begin
            acc_d = acc_q + opa_q;
          end
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      nosh_q   <= 1'b0;
      ctl_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      nosh_q   <= nosh_d;
      ctl_q    <= ctl_d;
      err_q    <= err_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign ALUCtl    = ctl_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_mc_unit.sv
// Testbench for alu_mc_unit (DATA_W=64): a table of operations with
// hand-derived results, plus a scoreboard monitor that checks every handoff.
module tb_alu_mc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] opcode;
  logic [1:0]  ALUOp;
  logic [5:0]  shamt;
  logic [63:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic [3:0]  ALUCtl;
  logic        err;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  aluop;
    logic [10:0] opc;
    logic [5:0]  sh;
    logic [63:0] va;
    logic [63:0] vb;
    logic [63:0] res;
    logic [3:0]  ctl;
    logic        er;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  ctl;
    logic        er;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[17];

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_EOR = 11'b11001010000;
  localparam logic [10:0] OP_LSL = 11'b11010011011;
  localparam logic [10:0] OP_LSR = 11'b11010011010;
  localparam logic [10:0] OP_MUL = 11'b10011011000;

  alu_mc_unit #(.DATA_W(64), .SHAMT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .ALUOp(ALUOp), .shamt(shamt), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .ALUCtl(ALUCtl), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: pop and compare on every result handoff
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: got %h expected none", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("zero", 64'(zero), 64'(e.res == 64'd0));
        check("ALUCtl", 64'(ALUCtl), 64'(e.ctl));
        check("err", 64'(err), 64'(e.er));
      end
    end
  end

  // Present a request, wait for acceptance, record the expectation
  task automatic accept(input vec_t v);
    int n;
    @(negedge clk);
    ALUOp = v.aluop; opcode = v.opc; shamt = v.sh; a = v.va; b = v.vb;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    sb.push_back('{res: v.res, ctl: v.ctl, er: v.er});
    #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    shamt = 6'($urandom); opcode = 11'($urandom); ALUOp = 2'($urandom);
    check("busy_not_ready", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_out(input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("return_idle", 64'(in_ready), 64'd1);
  endtask

  task automatic issue(input vec_t v);
    accept(v);
    wait_out(v.lat);
    wait_idle();
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{2'b00, 11'bx,          6'd0,  64'd5,                 64'd7,                 64'd12,                4'b0010, 1'b0, 1};
    vecs[1]  = '{2'b10, OP_SUB,         6'd0,  64'd9,                 64'd9,                 64'd0,                 4'b0110, 1'b0, 1};
    vecs[2]  = '{2'b10, OP_SUB,         6'd0,  64'd0,                 64'd1,                 64'hFFFF_FFFF_FFFF_FFFF, 4'b0110, 1'b0, 1};
    vecs[3]  = '{2'b10, OP_AND,         6'd0,  64'hF0F0,              64'hFF00,              64'hF000,              4'b0000, 1'b0, 1};
    vecs[4]  = '{2'b10, OP_ORR,         6'd0,  64'hF0F0,              64'h0F0F,              64'hFFFF,              4'b0001, 1'b0, 1};
    vecs[5]  = '{2'b10, OP_EOR,         6'd0,  64'hFF00,              64'h0FF0,              64'hF0F0,              4'b0011, 1'b0, 1};
    vecs[6]  = '{2'b10, OP_ADD,         6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,               64'd0,                 4'b0010, 1'b0, 1};
    vecs[7]  = '{2'b01, 11'b11111111111, 6'd0, 64'd3,                 64'h55,                64'h55,                4'b0111, 1'b0, 1};
    vecs[8]  = '{2'b10, OP_LSL,         6'd63, 64'd1,                 64'd0,                 64'h8000_0000_0000_0000, 4'b0100, 1'b0, 64};
    vecs[9]  = '{2'b10, OP_LSR,         6'd0,  64'h8000_0000_0000_0000, 64'd0,               64'h8000_0000_0000_0000, 4'b0101, 1'b0, 2};
    vecs[10] = '{2'b10, OP_LSR,         6'd4,  64'h8000_0000_0000_0001, 64'd0,               64'h0800_0000_0000_0000, 4'b0101, 1'b0, 5};
    vecs[11] = '{2'b10, OP_LSL,         6'd1,  64'd3,                 64'd0,                 64'd6,                 4'b0100, 1'b0, 2};
    vecs[12] = '{2'b10, OP_MUL,         6'd0,  64'h1_0000_0003,       64'h1_0000_0005,       64'h8_0000_000F,       4'b1000, 1'b0, 65};
    vecs[13] = '{2'b10, OP_MUL,         6'd0,  64'd7,                 64'd6,                 64'd42,                4'b1000, 1'b0, 65};
    vecs[14] = '{2'b10, 11'b11111111111, 6'd0, 64'd4,                 64'd4,                 64'd0,                 4'b1111, 1'b1, 1};
    vecs[15] = '{2'b01, 11'd0,          6'd0,  64'd0,                 64'h55,                64'h55,                4'b0111, 1'b0, 1};
    vecs[16] = '{2'b11, OP_ADD,         6'd0,  64'd1,                 64'd2,                 64'd0,                 4'b1111, 1'b1, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = '0; opcode = '0; shamt = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_ALUCtl", 64'(ALUCtl), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_zero", 64'(zero), 64'd0);

    for (int i = 0; i < 17; i++) issue(vecs[i]);

    // Result held stable while the consumer stalls
    out_ready = 1'b0;
    accept(vecs[12]);
    wait_out(65);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_result", result, 64'h8_0000_000F);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    // Reset during the 20th multiply iteration discards the operation
    accept(vecs[13]);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_zero", 64'(zero), 64'd0);
    check("midrst_ALUCtl", 64'(ALUCtl), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    v = vecs[0];
    v.opc = 11'd0; v.va = 64'd100; v.vb = 64'd23; v.res = 64'd123;
    issue(v);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
